pix_row_scheduler: RTL
======================

// Module: pix_row_scheduler
// PURPOSE
//  Clocked scheduler feeding packed 5-pixel rows to NUM_PE pixel-memory PEs for a 3-row CONV filter.
//  - Output row o is owned by PE (o % NUM_PE).
//  - Each input row r is dispatched once to every owner of an output row o with o <= r <= o+2 and o <= ROWS-3.
//  - Sits between the row source (memory/DMA) and the PE array. Replaces the PEs' implicit row-reuse counting.
// PARAMETERS
//  DWIDTH  8  bits per pixel
//  ROWS    5  input rows per frame (>=3; output rows = ROWS-2)
//  NUM_PE  3  number of PEs (>=3, so the targets of one row are distinct PEs)
//  RW      $clog2(ROWS)  row-index width (localparam)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous reset, active high
//  start       in   1          one-cycle pulse, begins a frame (honoured only in IDLE)
//  busy        out  1          high from start acceptance until frame_done
//  frame_done  out  1          one-cycle pulse after the final dispatch
//  in_data     in   DWIDTH*5   packed row; pixel4 in the MSBs
//  in_valid    in   1          source has a row
//  in_ready    out  1          scheduler accepts a row
//  pe_data     out  DWIDTH*5   captured row, shared by all PEs
//  pe_valid    out  NUM_PE     one-hot; dispatch to PE i
//  pe_ready    in   NUM_PE     PE i accepts
//  pe_tap      out  2          r-o: filter row index of this dispatch (0..2)
//  pe_orow     out  RW         output row index o of this dispatch
//  stall_cnt   out  32         only with PIX_SCHED_STATS_EN
// BEHAVIOUR
//  Reset: state=IDLE; busy, frame_done, in_ready, pe_valid = 0; pe_data, pe_tap, pe_orow = 0; row cnt r=0.
//  FSM:
//   IDLE -> LOAD on start (r=0).
//   LOAD: in_ready=1. On in_valid&in_ready, capture in_data into the row buffer.
//         Set o = max(0,r-2) and o_end = min(r,ROWS-3), then go to DISPATCH.
//   DISPATCH: pe_valid[o%NUM_PE]=1; pe_tap=r-o; pe_orow=o; pe_data=row buffer.
//         On the matching pe_ready the transfer completes that cycle.
//         If o<o_end: o++ and the next target is presented the next cycle (no bubble).
//         Else if r<ROWS-1: r++ -> LOAD.
//         Else -> DONE.
//   DONE: frame_done=1 for exactly one cycle -> IDLE; busy drops with frame_done.
//  Handshake:
//   - All outputs are registered.
//   - pe_valid, pe_data, pe_tap and pe_orow are held stable until the handshake completes.
//   - pe_ready of non-selected PEs is ignored.
//   - The first pe_valid appears in the cycle after the in_valid&in_ready cycle.
//  Ordering: targets of one row go in ascending o. A new row is never accepted before all targets of the current row are dispatched.
//  Row targets for ROWS=5, NUM_PE=3, as (PE, tap):
//   r0: (0,0)
//   r1: (0,1) (1,0)
//   r2: (0,2) (1,1) (2,0)
//   r3: (1,2) (2,1)
//   r4: (2,2)
//   9 dispatches per frame.
//  Boundaries:
//   - start while busy is ignored.
//   - A PE that never asserts ready stalls the scheduler indefinitely; there is no timeout.
//   - ROWS=3 gives one target per row, all to PE0.
//   - rst mid-frame returns to IDLE immediately and discards the row buffer; no frame_done is emitted.
//   - Elaboration $error if ROWS<3 or NUM_PE<3.
// CONFIGURATION
//  PIX_SCHED_STATS_EN
//   - Defined: stall_cnt counts DISPATCH cycles with pe_valid high and selected ready low.
//     It clears on start acceptance and on rst, saturates at 2^32-1, and holds after frame_done.
//   - Undefined: stall_cnt port and counter are absent.
// TESTING
//  1. ROWS=5, NUM_PE=3, all ready high, in_valid high:
//     exact 9-dispatch (PE,tap,orow) sequence above; frame_done exactly once; busy low afterwards.
//  2. Hold pe_ready[1]=0 for 4 cycles during r1:
//     pe_valid=3'b010 and pe_data stable throughout; in_ready stays low; stall_cnt=4 (STATS_EN).
//  3. in_valid low 3 cycles between rows:
//     in_ready held high in LOAD, no pe_valid, no dispatch reorder.
//  4. Assert rst during r2's second dispatch, then start:
//     outputs zero immediately; new frame restarts at r0 with (PE0,tap0).
//  5. start pulsed mid-frame:
//     ignored; dispatch count still 9.
//  6. ROWS=3:
//     three dispatches to PE0 with tap 0,1,2 and orow 0.

Source files
------------

// File: rtl/pix_row_if.sv
// ----------------------------------------------------------------------------
// pix_row_if
//   Bundles the control, row-source and PE-array handshake signals of the
//   pix_row_scheduler.
//   master : the scheduler side (drives busy/frame_done/in_ready/pe_*)
//   slave  : the environment side (drives start/in_data/in_valid/pe_ready)
// Parameters
//   DWIDTH  bits per pixel (rows are 5 pixels, pixel4 in the MSBs)
//   NUM_PE  number of PEs (width of pe_valid / pe_ready)
//   RW      output-row index width, must equal $clog2(ROWS) of the scheduler
// ----------------------------------------------------------------------------
interface pix_row_if #(
   parameter int DWIDTH = 8,
   parameter int NUM_PE = 3,
   parameter int RW     = 3
);
   logic                  start;
   logic                  busy;
   logic                  frame_done;
   logic [DWIDTH*5-1:0]   in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DWIDTH*5-1:0]   pe_data;
   logic [NUM_PE-1:0]     pe_valid;
   logic [NUM_PE-1:0]     pe_ready;
   logic [1:0]            pe_tap;
   logic [RW-1:0]         pe_orow;

   modport master (
      input  start, in_data, in_valid, pe_ready,
      output busy, frame_done, in_ready, pe_data, pe_valid, pe_tap, pe_orow
   );

   modport slave (
      output start, in_data, in_valid, pe_ready,
      input  busy, frame_done, in_ready, pe_data, pe_valid, pe_tap, pe_orow
   );
endinterface

// File: rtl/pix_row_scheduler.sv
// ----------------------------------------------------------------------------
// pix_row_scheduler
//   Feeds packed 5-pixel rows to NUM_PE pixel-memory PEs for a 3-row CONV
//   filter. Output row o belongs to PE (o % NUM_PE); each input row r is sent
//   once to every owner of an output row o with o <= r <= o+2, o <= ROWS-3,
//   in ascending o. The tap (r-o) and output row index travel with the data.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   bus        pix_row_if.master:
//                start/busy/frame_done  frame control
//                in_data/in_valid/in_ready  row source handshake
//                pe_data/pe_valid(one-hot)/pe_ready/pe_tap/pe_orow  PE dispatch
//   stall_cnt  32-bit count of stalled dispatch cycles; present only when the
//              macro PIX_SCHED_STATS_EN is defined
// ----------------------------------------------------------------------------
module pix_row_scheduler #(
   parameter int DWIDTH = 8,
   parameter int ROWS   = 5,
   parameter int NUM_PE = 3
) (
   input  logic         clk,
   input  logic         rst,
   pix_row_if.master    bus
`ifdef PIX_SCHED_STATS_EN
   ,
   output logic [31:0]  stall_cnt
`endif
);

   localparam int RW = $clog2(ROWS);
   localparam int PW = DWIDTH * 5;
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [RW-1:0] LAST_OROW = RW'(ROWS - 3);

   generate
      if (ROWS < 3 || NUM_PE < 3) begin : g_bad_cfg
         $error("pix_row_scheduler: needs ROWS >= 3 and NUM_PE >= 3");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DISPATCH,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       r_q, r_d;           // current input row
   logic [RW-1:0]       o_q, o_d;           // current target output row
   logic [RW-1:0]       o_end_q, o_end_d;   // last target output row of r
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                in_ready_q, in_ready_d;
   logic [PW-1:0]       pe_data_q, pe_data_d;
   logic [NUM_PE-1:0]   pe_valid_q, pe_valid_d;
   logic [1:0]          pe_tap_q, pe_tap_d;
   logic [RW-1:0]       pe_orow_q, pe_orow_d;
`ifdef PIX_SCHED_STATS_EN
   logic [31:0]         stall_q, stall_d;
`endif

   logic [RW-1:0]       o_first;   // max(0, r-2)
   logic [RW-1:0]       o_last;    // min(r, ROWS-3)
   logic [RW-1:0]       o_next;
   logic                pe_fire;

   function automatic logic [NUM_PE-1:0] owner_onehot(input logic [RW-1:0] orow);
      logic [NUM_PE-1:0] oh;
      for (int i = 0; i < NUM_PE; i++) begin
         oh[i] = ((int'(orow) % NUM_PE) == i);
      end
      return oh;
   endfunction

   function automatic logic [1:0] tap_of(input logic [RW-1:0] row, input logic [RW-1:0] orow);
      return 2'(row - orow);
   endfunction

   assign o_first = (r_q >= RW'(2)) ? (r_q - RW'(2)) : '0;
   assign o_last  = (r_q < LAST_OROW) ? r_q : LAST_OROW;
   assign o_next  = o_q + RW'(1);
   // Only the selected PE's ready matters: pe_valid_q is one-hot.
   assign pe_fire = |(pe_valid_q & bus.pe_ready);

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      state_d      = state_q;
      r_d          = r_q;
      o_d          = o_q;
      o_end_d      = o_end_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      in_ready_d   = in_ready_q;
      pe_data_d    = pe_data_q;
      pe_valid_d   = pe_valid_q;
      pe_tap_d     = pe_tap_q;
      pe_orow_d    = pe_orow_q;
`ifdef PIX_SCHED_STATS_EN
      stall_d      = stall_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_LOAD;
               r_d        = '0;
               busy_d     = 1'b1;
               in_ready_d = 1'b1;
`ifdef PIX_SCHED_STATS_EN
               stall_d    = '0;
`endif
            end
         end

         S_LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               pe_data_d  = bus.in_data;
               o_d        = o_first;
               o_end_d    = o_last;
               in_ready_d = 1'b0;
               pe_valid_d = owner_onehot(o_first);
               pe_tap_d   = tap_of(r_q, o_first);
               pe_orow_d  = o_first;
               state_d    = S_DISPATCH;
            end
         end

         S_DISPATCH: begin
`ifdef PIX_SCHED_STATS_EN
            if (!pe_fire && stall_q != 32'hFFFF_FFFF) begin
               stall_d = stall_q + 32'd1;
            end
`endif
            if (pe_fire) begin
               if (o_q < o_end_q) begin
                  // Present the next target straight away (no bubble).
                  o_d        = o_next;
                  pe_valid_d = owner_onehot(o_next);
                  pe_tap_d   = tap_of(r_q, o_next);
                  pe_orow_d  = o_next;
               end else begin
                  pe_valid_d = '0;
                  if (r_q < LAST_ROW) begin
                     r_d        = r_q + RW'(1);
                     in_ready_d = 1'b1;
                     state_d    = S_LOAD;
                  end else begin
                     frame_done_d = 1'b1;
                     busy_d       = 1'b0;
                     state_d      = S_DONE;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The row buffer (pe_data) is only five pixels wide and drives a visible
   // output, so it is reset together with the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         r_q          <= '0;
         o_q          <= '0;
         o_end_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         in_ready_q   <= 1'b0;
         pe_data_q    <= '0;
         pe_valid_q   <= '0;
         pe_tap_q     <= '0;
         pe_orow_q    <= '0;
`ifdef PIX_SCHED_STATS_EN
         stall_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments make every flop sample the values
         // from before the edge, independent of statement order.
         state_q      <= state_d;
         r_q          <= r_d;
         o_q          <= o_d;
         o_end_q      <= o_end_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         in_ready_q   <= in_ready_d;
         pe_data_q    <= pe_data_d;
         pe_valid_q   <= pe_valid_d;
         pe_tap_q     <= pe_tap_d;
         pe_orow_q    <= pe_orow_d;
`ifdef PIX_SCHED_STATS_EN
         stall_q      <= stall_d;
`endif
      end
   end

   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.in_ready   = in_ready_q;
   assign bus.pe_data    = pe_data_q;
   assign bus.pe_valid   = pe_valid_q;
   assign bus.pe_tap     = pe_tap_q;
   assign bus.pe_orow    = pe_orow_q;
`ifdef PIX_SCHED_STATS_EN
   assign stall_cnt      = stall_q;
`endif

endmodule
